// File: rtl/mips_datapath_immediate_extend_shift_pipe.sv
// mips_datapath_immediate_extend_shift_pipe
//
// Two-stage valid/ready immediate generator for the ID/EX boundary.
//   Stage 1: extends the IMM_W-bit immediate to WORD_W bits (zero, sign or one fill).
//   Stage 2: shifts the extended word by a run-time amount and flags lost 1-bits.
// A sideband tag travels with each immediate unchanged.
//
// Build option:
//   MIPS_DATAPATH_IMMEDIATE_RIGHT_SHIFT_EN - when defined, shiftMode 10 (right logical)
//   and 11 (right arithmetic) are implemented; otherwise they behave as "none" and
//   the right shifter is not built.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   inValid/inReady   - input handshake (inReady never depends on inValid)
//   immIn, extend     - raw immediate and fill select (00 zero, 01 sign, 10 one, 11 sign)
//   shiftMode, shamt  - 00 none, 01 left, 10 right logical, 11 right arithmetic; amount
//   tagIn/tagOut      - sideband tag in/out
//   outValid/outReady - output handshake
//   immOut, lostBits  - shifted word and "a 1-bit fell off the word" flag
//   busy              - either stage holds a valid entry
//
// Parameter constraints: IMM_W < WORD_W, WORD_W a power of two, SHAMT_W = log2(WORD_W).

module mips_datapath_immediate_extend_shift_pipe #(
    parameter int IMM_W   = 16,
    parameter int WORD_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [IMM_W-1:0]   immIn,
    input  logic [1:0]         extend,
    input  logic [1:0]         shiftMode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [TAG_W-1:0]   tagIn,
    output logic               outValid,
    input  logic               outReady,
    output logic [WORD_W-1:0]  immOut,
    output logic               lostBits,
    output logic [TAG_W-1:0]   tagOut,
    output logic               busy
);

    localparam int FILL_W = WORD_W - IMM_W;
    localparam logic [WORD_W-1:0] ALL_ONES = '1;

    // Stage 1 state
    logic               s1_valid_reg;
    logic [WORD_W-1:0]  ext_reg;
    logic [1:0]         mode_reg;
    logic [SHAMT_W-1:0] shamt_reg;
    logic [TAG_W-1:0]   tag_s1_reg;

    // Stage 2 state (drives the outputs directly)
    logic               s2_valid_reg;
    logic [WORD_W-1:0]  imm_out_reg;
    logic               lost_reg;
    logic [TAG_W-1:0]   tag_out_reg;

    logic               s1_adv;
    logic               fill_bit;
    logic [FILL_W-1:0]  fill;
    logic [WORD_W-1:0]  shift_next;
    logic               lost_next;

    // Stage 1 may hand its entry on whenever stage 2 is empty or is being drained.
    assign s1_adv  = !s2_valid_reg || outReady;
    assign inReady = !s1_valid_reg || s1_adv;

    // Fill value: 00 zero, 10 one, 01/11 replicate the immediate's sign bit.
    always_comb begin
        fill_bit = immIn[IMM_W-1];
        case (extend)
            2'b00:   fill_bit = 1'b0;
            2'b10:   fill_bit = 1'b1;
            default: fill_bit = immIn[IMM_W-1];
        endcase
    end

    generate
        for (genvar gi = 0; gi < FILL_W; gi++) begin : g_fill
            assign fill[gi] = fill_bit;
        end
    endgenerate

    // Shifter and lost-bit detector. The lost-bit masks select the bits pushed past
    // the word edge; with shamt = 0 the mask is empty, so the flag is 0 for free.
    always_comb begin
        shift_next = ext_reg;
        lost_next  = 1'b0;
        case (mode_reg)
            2'b01: begin
                shift_next = ext_reg << shamt_reg;
                lost_next  = |(ext_reg & ~(ALL_ONES >> shamt_reg));
            end
`ifdef MIPS_DATAPATH_IMMEDIATE_RIGHT_SHIFT_EN
            2'b10: begin
                shift_next = ext_reg >> shamt_reg;
                lost_next  = |(ext_reg & ~(ALL_ONES << shamt_reg));
            end
            2'b11: begin
                shift_next = $unsigned($signed(ext_reg) >>> shamt_reg);
                lost_next  = |(ext_reg & ~(ALL_ONES << shamt_reg));
            end
`endif
            default: begin
                shift_next = ext_reg;
                lost_next  = 1'b0;
            end
        endcase
    end

    // Stage 1: when ready, either load a new request or go empty (the old entry,
    // if any, is advancing into stage 2 on this same edge).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            ext_reg      <= '0;
            mode_reg     <= '0;
            shamt_reg    <= '0;
            tag_s1_reg   <= '0;
        end else if (inReady) begin
            s1_valid_reg <= inValid;
            if (inValid) begin
                ext_reg    <= {fill, immIn};
                mode_reg   <= shiftMode;
                shamt_reg  <= shamt;
                tag_s1_reg <= tagIn;
            end
        end
    end

    // Stage 2: data only changes on a real load, so outputs hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            imm_out_reg  <= '0;
            lost_reg     <= 1'b0;
            tag_out_reg  <= '0;
        end else if (s1_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                imm_out_reg <= shift_next;
                lost_reg    <= lost_next;
                tag_out_reg <= tag_s1_reg;
            end
        end
    end

    assign outValid = s2_valid_reg;
    assign immOut   = imm_out_reg;
    assign lostBits = lost_reg;
    assign tagOut   = tag_out_reg;
    assign busy     = s1_valid_reg || s2_valid_reg;

endmodule

// File: tb/tb_mips_datapath_immediate_extend_shift_pipe.sv
// Self-checking bench for mips_datapath_immediate_extend_shift_pipe (default parameters).
// Table of single-transaction vectors plus hand sequences for back-pressure and reset.

module tb_mips_datapath_immediate_extend_shift_pipe;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [15:0] immIn;
    logic [1:0]  extend;
    logic [1:0]  shiftMode;
    logic [4:0]  shamt;
    logic [3:0]  tagIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] immOut;
    logic        lostBits;
    logic [3:0]  tagOut;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mips_datapath_immediate_extend_shift_pipe dut (
        .clock    (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .immIn    (immIn),
        .extend   (extend),
        .shiftMode(shiftMode),
        .shamt    (shamt),
        .tagIn    (tagIn),
        .outValid (outValid),
        .outReady (outReady),
        .immOut   (immOut),
        .lostBits (lostBits),
        .tagOut   (tagOut),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  ext;
        logic [1:0]  mode;
        logic [4:0]  sh;
        logic [3:0]  tag;
        logic [31:0] exp_imm;
        logic        exp_lost;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        // Expected values computed by hand from the extend/shift definitions.
        vecs[0]  = '{16'h8001, 2'b01, 2'b01, 5'd2,  4'd3,  32'hFFFE0004, 1'b1};
        vecs[1]  = '{16'h1234, 2'b00, 2'b01, 5'd16, 4'd5,  32'h12340000, 1'b0};
        vecs[2]  = '{16'h8001, 2'b00, 2'b00, 5'd7,  4'd6,  32'h00008001, 1'b0};
        vecs[3]  = '{16'h8000, 2'b11, 2'b00, 5'd0,  4'd7,  32'hFFFF8000, 1'b0};
        vecs[4]  = '{16'h8001, 2'b01, 2'b01, 5'd0,  4'd8,  32'hFFFF8001, 1'b0};
        vecs[5]  = '{16'h0001, 2'b00, 2'b01, 5'd31, 4'd9,  32'h80000000, 1'b0};
        vecs[6]  = '{16'h0003, 2'b00, 2'b01, 5'd31, 4'd10, 32'h80000000, 1'b1};
        vecs[7]  = '{16'h7FFF, 2'b01, 2'b01, 5'd1,  4'd11, 32'h0000FFFE, 1'b0};
        vecs[8]  = '{16'h0001, 2'b10, 2'b01, 5'd4,  4'd12, 32'hFFF00010, 1'b1};
`ifdef MIPS_DATAPATH_IMMEDIATE_RIGHT_SHIFT_EN
        vecs[9]  = '{16'hFF00, 2'b01, 2'b11, 5'd4,  4'd13, 32'hFFFFFFF0, 1'b0};
        vecs[10] = '{16'h0003, 2'b10, 2'b10, 5'd1,  4'd14, 32'h7FFF8001, 1'b1};
        vecs[11] = '{16'h8000, 2'b01, 2'b10, 5'd31, 4'd15, 32'h00000001, 1'b1};
        vecs[12] = '{16'h7FF0, 2'b01, 2'b11, 5'd4,  4'd1,  32'h000007FF, 1'b0};
`else
        vecs[9]  = '{16'hFF00, 2'b01, 2'b11, 5'd4,  4'd13, 32'hFFFFFF00, 1'b0};
        vecs[10] = '{16'h0003, 2'b10, 2'b10, 5'd1,  4'd14, 32'hFFFF0003, 1'b0};
        vecs[11] = '{16'h8000, 2'b01, 2'b10, 5'd31, 4'd15, 32'hFFFF8000, 1'b0};
        vecs[12] = '{16'h7FF0, 2'b01, 2'b11, 5'd4,  4'd1,  32'h00007FF0, 1'b0};
`endif

        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        immIn = '0; extend = '0; shiftMode = '0; shamt = '0; tagIn = '0;
        #1;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_inReady",  32'(inReady),  32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_immOut",   immOut,        32'd0);
        chk("rst_lostBits", 32'(lostBits), 32'd0);
        chk("rst_tagOut",   32'(tagOut),   32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // ---- table-driven single transactions, outReady held high ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            inValid = 1'b1; immIn = vecs[i].imm; extend = vecs[i].ext;
            shiftMode = vecs[i].mode; shamt = vecs[i].sh; tagIn = vecs[i].tag;
            #1 chk($sformatf("v%0d_inReady", i), 32'(inReady), 32'd1);
            @(negedge clk);
            inValid = 1'b0;
            chk($sformatf("v%0d_lat1_outValid", i), 32'(outValid), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_outValid", i), 32'(outValid), 32'd1);
            chk($sformatf("v%0d_immOut", i),   immOut,        vecs[i].exp_imm);
            chk($sformatf("v%0d_lostBits", i), 32'(lostBits), 32'(vecs[i].exp_lost));
            chk($sformatf("v%0d_tagOut", i),   32'(tagOut),   32'(vecs[i].tag));
            $display("vec %0d: imm=%h ext=%b mode=%b sh=%0d -> immOut=%h lost=%b tag=%0d",
                     i, vecs[i].imm, vecs[i].ext, vecs[i].mode, vecs[i].sh, immOut, lostBits, tagOut);
        end
        @(negedge clk);
        chk("drain_outValid", 32'(outValid), 32'd0);
        chk("drain_busy",     32'(busy),     32'd0);

        // ---- back-pressure: tags 0..5 offered every cycle, outReady 1,0,0,1,... ----
        begin
            int next_tag = 0;
            int got = 0;
            int cnt = 0;
            int cyc = 0;
            logic in_x, out_x;
            while (got < 6 && cyc < 200) begin
                @(negedge clk);
                outReady  = (cyc % 4 == 0) || (cyc % 4 == 3);
                inValid   = (next_tag < 6);
                tagIn     = 4'(next_tag);
                immIn     = 16'(next_tag * 16'h0111);
                extend    = 2'b00; shiftMode = 2'b00; shamt = 5'd0;
                #1;
                chk("bp_inReady", 32'(inReady), 32'(!(cnt == 2 && !outReady)));
                chk("bp_busy",    32'(busy),    32'(cnt != 0));
                in_x  = inValid && inReady;
                out_x = outValid && outReady;
                if (out_x) begin
                    chk("bp_tag_order", 32'(tagOut), 32'(got));
                    chk("bp_immOut",    immOut,      32'(got * 32'h0111));
                    $display("bp cycle %0d: retired tag=%0d imm=%h", cyc, tagOut, immOut);
                    got++;
                end
                @(posedge clk);
                cnt = cnt + int'(in_x) - int'(out_x);
                if (in_x) next_tag++;
                cyc++;
            end
            if (cyc >= 200) chk("bp_timeout", 32'(got), 32'd6);
            inValid = 1'b0;
            @(negedge clk);
            outReady = 1'b1;
            #1 chk("bp_no_duplicate", 32'(outValid), 32'd0);
        end

        // ---- reset mid-stream with two entries in flight ----
        @(negedge clk);
        outReady = 1'b0; inValid = 1'b1; tagIn = 4'd9; immIn = 16'h0009;
        @(negedge clk);
        tagIn = 4'd10; immIn = 16'h000A;
        @(negedge clk);
        inValid = 1'b0;
        #1;
        chk("full_inReady", 32'(inReady), 32'd0);
        chk("full_busy",    32'(busy),    32'd1);
        chk("full_tagOut",  32'(tagOut),  32'd9);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outValid", 32'(outValid), 32'd0);
        chk("mid_rst_busy",     32'(busy),     32'd0);
        chk("mid_rst_inReady",  32'(inReady),  32'd1);
        chk("mid_rst_tagOut",   32'(tagOut),   32'd0);
        $display("mid-stream reset: outValid=%b busy=%b inReady=%b", outValid, busy, inReady);
        @(negedge clk);
        reset = 1'b0; outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(outValid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
